as6501_cfg_seq: RTL and testbench
=================================

# as6501_cfg_seq

Sequencer that configures the AS6501 TDC over its SPI port before the frame/SDI readout interface is enabled. On a start pulse it issues power-on-reset, writes all configuration registers from a flat register image, reads them back and compares, issues the init opcode, then raises `cfg_done_o`, which software/top-level uses to drive `reg_enable_tdc_i` of the readout interface. Sits in the lclk_i domain alongside the TDC readout logic.

## Interface
- `NREG`, 17: number of config registers, at addresses 0..NREG-1.
- `CLK_DIV`, 2: SCK half-period in lclk_i cycles, ≥1.
- `SSN_GAP`, 4: lclk_i cycles SSN stays high between SPI frames, ≥1.
- `POR_WAIT`, 200: lclk_i cycles waited after the power-on-reset frame.
- `MAX_RETRY`, 3: readback-mismatch retries before error.

- `lclk_i` in 1: clock. One clock domain only.
- `lrst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: single-cycle pulse that starts a configuration run.
- `cfg_data_i` in 8*NREG: register image. Byte k is `[8k+7:8k]` and is the value for address k. It is sampled into an internal copy when `start_i` is accepted.
- `spi_sck_o` out 1: SPI clock, mode 1 (CPOL=0, CPHA=1).
- `spi_ssn_o` out 1: chip select, active-low.
- `spi_mosi_o` out 1: serial data out, MSB first.
- `spi_miso_i` in 1: serial data in.
- `busy_o` out 1: a run is in progress.
- `cfg_done_o` out 1: config verified and init sent. Held until the next accepted start or reset.
- `cfg_error_o` out 1: retries exhausted. Held until the next accepted start or reset.
- `retry_cnt_o` out 2: retries used in the current or last run.
- `mismatch_addr_o` out 5: address of the first mismatching byte in the last failed readback.

## Operation
- States: IDLE → POR → POR_WAIT → WRITE → GAP → READ → INIT → DONE. Failure path goes to ERROR.
- `start_i` is accepted only in IDLE, DONE or ERROR. It is ignored while `busy_o`=1. Acceptance clears `cfg_done_o`, `cfg_error_o` and `retry_cnt_o`, and latches `cfg_data_i`.
- POR: one frame carrying opcode 0x30. Then POR_WAIT counts POR_WAIT cycles with SSN high.
- WRITE: a single SSN-low frame. It sends opcode 0x80 (write config, start address 0), then NREG bytes in address order 0..NREG-1.
- READ: a single frame. It sends opcode 0x40, then clocks out NREG bytes of 0x00 while capturing MISO. Each received byte is compared with the latched image as soon as it completes.
- Mismatch handling happens at the end of the READ frame:
  - `mismatch_addr_o` is set to the lowest mismatching address.
  - If `retry_cnt_o` < MAX_RETRY: increment it and return to WRITE (not POR).
  - Otherwise go to ERROR.
- INIT: one frame with opcode 0x18. Then go to DONE.
- Between any two frames, SSN is high for exactly SSN_GAP cycles. This includes POR→POR_WAIT, which is covered by POR_WAIT ≥ SSN_GAP.
- `busy_o` = 1 in every state except IDLE, DONE and ERROR.

## Timing
- Reset values: `spi_ssn_o`=1, `spi_sck_o`=0, `spi_mosi_o`=0, `busy_o`=0, `cfg_done_o`=0, `cfg_error_o`=0, `retry_cnt_o`=0, `mismatch_addr_o`=0. State is IDLE.
- Reset asserted mid-frame: on the next edge SSN goes high and SCK goes low, with no completion of the partial byte.
- The cycle after `start_i` is accepted, `busy_o`=1 and the POR frame begins.
- Frame timing:
  - SSN falls, then the first SCK rising edge follows CLK_DIV cycles later.
  - Each bit lasts 2*CLK_DIV cycles.
  - MOSI updates on the SCK rising edge. MISO is sampled on the SCK falling edge.
  - After the last falling edge, SSN rises CLK_DIV cycles later. SCK idles low.
- Frame length in bits: POR = 8, WRITE = 8+8*NREG, READ = 8+8*NREG, INIT = 8.
- `cfg_done_o` rises on the same edge that SSN rises at the end of the INIT frame, plus one cycle. `busy_o` falls on that same edge.
- `cfg_error_o` rises one cycle after the end of the final failed READ frame. `busy_o` falls with it.
- Byte and bit counters are sized for NREG up to 31. Address wraps are not permitted; NREG > 31 is illegal.

## Test plan
- NREG=17, CLK_DIV=2. Apply reset, then pulse start with image bytes k = 0xA0+k, and a MISO model that echoes written registers → expect:
  - MOSI sequence 0x30, then 0x80, then A0..B0, then 0x40 + 17×0x00, then 0x18.
  - `cfg_done_o`=1, `cfg_error_o`=0, `retry_cnt_o`=0.
  - Every SCK high/low phase lasts 2 cycles. SSN gaps are 4 cycles.
- Model corrupts address 5 on the first readback only → a second WRITE frame is issued without POR, `retry_cnt_o`=1, `mismatch_addr_o`=5, `cfg_done_o`=1.
- Model always returns 0xFF → 4 WRITE/READ pairs, then `cfg_error_o`=1, `retry_cnt_o`=3, `mismatch_addr_o`=0, `busy_o`=0, and no INIT frame.
- Pulse `start_i` again during the WRITE frame → no effect on sequence or counters. Pulse it after DONE → flags clear and the full sequence reruns.
- Assert `lrst_i` for 1 cycle in the middle of the READ frame → next edge has SSN=1, SCK=0, `busy_o`=0, all flags 0. A fresh start then completes normally.

Source files
------------

// File: rtl/as6501_cfg_seq.sv
// AS6501 TDC SPI configuration sequencer: POR, write image, verify, init.
// Drives SPI mode 1 frames from a half-period counter in the lclk_i domain.
module as6501_cfg_seq #(
  parameter int NREG      = 17,
  parameter int CLK_DIV   = 2,
  parameter int SSN_GAP   = 4,
  parameter int POR_WAIT  = 200,
  parameter int MAX_RETRY = 3
) (
  input  logic              lclk_i,
  input  logic              lrst_i,
  input  logic              start_i,
  input  logic [8*NREG-1:0] cfg_data_i,
  output logic              spi_sck_o,
  output logic              spi_ssn_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              busy_o,
  output logic              cfg_done_o,
  output logic              cfg_error_o,
  output logic [1:0]        retry_cnt_o,
  output logic [4:0]        mismatch_addr_o
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_POR   = 4'd1;
  localparam logic [3:0] S_PORW  = 4'd2;
  localparam logic [3:0] S_WRITE = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;
  localparam logic [3:0] S_READ  = 4'd5;
  localparam logic [3:0] S_INIT  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  // halves: lead, 2 per bit; SSN rises on entering the last one
  localparam logic [9:0]  LONG_H  = 10'(16*NREG+17);
  localparam logic [9:0]  SHORT_H = 10'd17;
  localparam logic [15:0] DIV_L   = 16'(CLK_DIV-1);
  localparam logic [15:0] GAP_L   = 16'(SSN_GAP-1);
  localparam logic [15:0] PORW_L  = 16'(POR_WAIT-1);
  localparam logic [1:0]  RETRY_L = 2'(MAX_RETRY);

  logic [3:0]        state_q, state_d, nxt_q, nxt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [9:0]        half_q, half_d, half_n, last_h;
  logic              ssn_q, ssn_d, sck_q, sck_d, mosi_q, mosi_d;
  logic [7:0]        rx_q, rx_d, rx_full;
  logic              mm_seen_q, mm_seen_d;
  logic [4:0]        mm_addr_q, mm_addr_d, mis_q, mis_d;
  logic [1:0]        retry_q, retry_d;
  logic              done_q, done_d, err_q, err_d;
  logic [8*NREG-1:0] img_q, img_d;
  logic [7:0]        tx_b, rx_b, op, tx_byte;
  logic              frame_go;

  function automatic logic [7:0] img_at(
    input logic [8*NREG-1:0] img,
    input logic [4:0]        a
  );
    return img[8*a +: 8];
  endfunction

  always_comb begin
    half_n  = half_q + 10'd1;
    last_h  = (state_q == S_WRITE || state_q == S_READ) ? LONG_H : SHORT_H;
    tx_b    = 8'(half_q >> 1);
    rx_b    = 8'((half_q - 10'd1) >> 1);
    rx_full = {rx_q[6:0], spi_miso_i};
    op      = 8'h18;
    if (state_q == S_POR)   op = 8'h30;
    if (state_q == S_WRITE) op = 8'h80;
    if (state_q == S_READ)  op = 8'h40;
    tx_byte = 8'h00;
    if (tx_b[7:3] == 5'd0) tx_byte = op;
    else if (state_q == S_WRITE) tx_byte = img_at(img_q, tx_b[7:3] - 5'd1);
  end

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    ssn_d     = ssn_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    rx_d      = rx_q;
    mm_seen_d = mm_seen_q;
    mm_addr_d = mm_addr_q;
    mis_d     = mis_q;
    retry_d   = retry_q;
    done_d    = done_q;
    err_d     = err_q;
    img_d     = img_q;
    frame_go  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d  = S_POR;
          frame_go = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          retry_d  = 2'd0;
          img_d    = cfg_data_i;
        end
      end
      S_POR, S_WRITE, S_READ, S_INIT: begin
        if (cnt_q != DIV_L) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d  = 16'd0;
          half_d = half_n;
          if (half_n == last_h) begin
            ssn_d   = 1'b1;
            state_d = S_GAP;
            if (state_q == S_POR) state_d = S_PORW;
            if (state_q == S_WRITE) nxt_d = S_READ;
            if (state_q == S_INIT) nxt_d = S_DONE;
            if (state_q == S_READ) begin
              nxt_d = S_INIT;
              if (mm_seen_q) begin
                mis_d = mm_addr_q;
                if (retry_q < RETRY_L) begin
                  retry_d = retry_q + 2'd1;
                  nxt_d   = S_WRITE;
                end else begin
                  nxt_d = S_ERR;
                end
              end
            end
          end else if (half_n[0]) begin
            sck_d  = 1'b1;
            mosi_d = tx_byte[~tx_b[2:0]];
          end else begin
            sck_d = 1'b0;
            rx_d  = rx_full;
            // first mismatch of the frame wins
            if (state_q == S_READ && rx_b[2:0] == 3'd7 &&
                rx_b[7:3] != 5'd0 && !mm_seen_q &&
                rx_full != img_at(img_q, rx_b[7:3] - 5'd1)) begin
              mm_seen_d = 1'b1;
              mm_addr_d = rx_b[7:3] - 5'd1;
            end
          end
        end
      end
      S_PORW: begin
        if (cnt_q == PORW_L) begin
          state_d  = S_WRITE;
          frame_go = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (nxt_q == S_DONE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (nxt_q == S_ERR) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (cnt_q == GAP_L) begin
          state_d  = nxt_q;
          frame_go = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_go) begin
      ssn_d     = 1'b0;
      cnt_d     = 16'd0;
      half_d    = 10'd0;
      mm_seen_d = 1'b0;
    end
  end

  always_ff @(posedge lclk_i) begin
    if (lrst_i) begin
      state_q   <= S_IDLE;
      nxt_q     <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      ssn_q     <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      rx_q      <= '0;
      mm_seen_q <= 1'b0;
      mm_addr_q <= '0;
      mis_q     <= '0;
      retry_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      img_q     <= '0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      ssn_q     <= ssn_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      rx_q      <= rx_d;
      mm_seen_q <= mm_seen_d;
      mm_addr_q <= mm_addr_d;
      mis_q     <= mis_d;
      retry_q   <= retry_d;
      done_q    <= done_d;
      err_q     <= err_d;
      img_q     <= img_d;
    end
  end

  assign spi_sck_o       = sck_q;
  assign spi_ssn_o       = ssn_q;
  assign spi_mosi_o      = mosi_q;
  assign busy_o          = !(state_q == S_IDLE || state_q == S_DONE ||
                             state_q == S_ERR);
  assign cfg_done_o      = done_q;
  assign cfg_error_o     = err_q;
  assign retry_cnt_o     = retry_q;
  assign mismatch_addr_o = mis_q;

endmodule

// File: tb/tb_as6501_cfg_seq.sv
// Bench for as6501_cfg_seq: SPI slave model with echo/corrupt/0xFF readback
// and a scoreboard of expected MOSI bytes.
module tb_as6501_cfg_seq;

  localparam int NREG     = 17;
  localparam int CLK_DIV  = 2;
  localparam int SSN_GAP  = 4;
  localparam int POR_WAIT = 200;

  logic              clk = 1'b0;
  logic              lrst = 1'b1;
  logic              start = 1'b0;
  logic [8*NREG-1:0] cfg_data = '0;
  logic              miso = 1'b0;
  logic              sck, ssn, mosi, busy, done, err;
  logic [1:0]        retry;
  logic [4:0]        mm;

  as6501_cfg_seq #(
    .NREG(NREG), .CLK_DIV(CLK_DIV), .SSN_GAP(SSN_GAP),
    .POR_WAIT(POR_WAIT), .MAX_RETRY(3)
  ) dut (
    .lclk_i(clk), .lrst_i(lrst), .start_i(start),
    .cfg_data_i(cfg_data), .spi_sck_o(sck), .spi_ssn_o(ssn),
    .spi_mosi_o(mosi), .spi_miso_i(miso), .busy_o(busy),
    .cfg_done_o(done), .cfg_error_o(err), .retry_cnt_o(retry),
    .mismatch_addr_o(mm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  logic [7:0] model[NREG];
  logic [7:0] shreg = 8'h00;
  logic [7:0] op = 8'h00;
  logic [7:0] last_op = 8'h00;
  logic pssn = 1'b1;
  logic psck = 1'b0;
  int cyc = 0, run_len = 0, gap_len = 0, frame_gap = 0, bits = 0;
  int t_rise = 0, ph_bad = 0, mode = 0, reads = 0;
  int np = 0, nw = 0, nr = 0, ni = 0;
  int np0, nw0, nr0, ni0, ph0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic byte_done(input logic [7:0] b);
    int idx;
    idx = bits / 8 - 1;
    if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
    else check_eq("mosi_byte", b, sb.pop_front());
    if (idx == 0) begin
      op = b;
      if (b != 8'h30)
        check_eq("ssn_gap", frame_gap,
                 last_op == 8'h30 ? POR_WAIT : SSN_GAP);
      if (b == 8'h40) reads++;
    end else if (op == 8'h80 && idx <= NREG) begin
      model[idx-1] = b;
    end
  endtask

  // one clock: sample DUT at negedge and run the slave model
  task automatic step();
    logic [7:0] v;
    int j;
    @(negedge clk);
    cyc++;
    if (lrst) begin
      sb.delete();
      pssn = 1'b1; psck = 1'b0; gap_len = 0;
      op = 8'h00; last_op = 8'h00; bits = 0; miso = 1'b0;
      return;
    end
    if (!ssn) begin
      if (pssn) begin
        run_len = 1; bits = 0; frame_gap = gap_len; op = 8'h00;
      end else if (sck != psck) begin
        if (run_len != CLK_DIV) ph_bad++;
        run_len = 1;
        if (psck) begin
          shreg = {shreg[6:0], mosi};
          bits++;
          if (bits % 8 == 0) byte_done(shreg);
        end else begin
          j = bits / 8;
          v = 8'h00;
          if (op == 8'h40 && j >= 1 && j <= NREG) begin
            v = (mode == 2) ? 8'hFF : model[j-1];
            if (mode == 1 && reads == 1 && j - 1 == 5) v = v ^ 8'h01;
          end
          miso = v[7 - bits % 8];
        end
      end else begin
        run_len++;
      end
    end else begin
      if (!pssn) begin
        if (run_len != CLK_DIV) ph_bad++;
        t_rise = cyc; gap_len = 0; last_op = op;
        if (op == 8'h30) np++;
        if (op == 8'h80) nw++;
        if (op == 8'h40) nr++;
        if (op == 8'h18) ni++;
      end
      gap_len++;
    end
    pssn = ssn;
    psck = sck;
  endtask

  task automatic begin_run(input logic [7:0] base, input logic [7:0] stp,
                           input int md, input int nwr, input bit init);
    mode = md; reads = 0;
    np0 = np; nw0 = nw; nr0 = nr; ni0 = ni; ph0 = ph_bad;
    sb.push_back(8'h30);
    for (int k = 0; k < NREG; k++) cfg_data[8*k +: 8] = base + 8'(k) * stp;
    for (int w = 0; w < nwr; w++) begin
      sb.push_back(8'h80);
      for (int k = 0; k < NREG; k++) sb.push_back(cfg_data[8*k +: 8]);
      sb.push_back(8'h40);
      for (int k = 0; k < NREG; k++) sb.push_back(8'h00);
    end
    if (init) sb.push_back(8'h18);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("ssn_after_start", ssn, 0);
    check_eq("done_cleared", done, 0);
    check_eq("err_cleared", err, 0);
    check_eq("retry_cleared", retry, 0);
  endtask

  task automatic finish_run(input bit poke, input int e_done, input int e_err,
                            input int e_retry, input int e_mm,
                            input int e_w, input int e_i);
    bit poked = 0;
    for (int i = 0; i < 8000 && !(done || err); i++) begin
      step();
      if (poke && !poked && op == 8'h80 && bits == 24) begin
        poked = 1;
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check_eq("run_end_seen", done | err, 1);
    check_eq("cfg_done", done, e_done);
    check_eq("cfg_error", err, e_err);
    check_eq("retry_cnt", retry, e_retry);
    check_eq("mismatch_addr", mm, e_mm);
    check_eq("busy_end", busy, 0);
    check_eq("flag_latency", cyc - t_rise, 1);
    check_eq("sb_left", sb.size(), 0);
    check_eq("sck_phase_bad", ph_bad - ph0, 0);
    check_eq("por_frames", np - np0, 1);
    check_eq("write_frames", nw - nw0, e_w);
    check_eq("read_frames", nr - nr0, e_w);
    check_eq("init_frames", ni - ni0, e_i);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ssn"}, ssn, 1);
    check_eq({tag, "_sck"}, sck, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_retry"}, retry, 0);
    check_eq({tag, "_mm"}, mm, 0);
  endtask

  initial begin
    lrst = 1'b1;
    step();
    step();
    check_reset_state("rst");
    check_eq("rst_mosi", mosi, 0);
    lrst = 1'b0;
    step();

    begin_run(8'hA0, 8'd1, 0, 1, 1);
    finish_run(1, 1, 0, 0, 0, 1, 1);
    repeat (10) step();
    check_eq("done_held", done, 1);

    begin_run(8'h11, 8'd13, 0, 1, 1);
    finish_run(0, 1, 0, 0, 0, 1, 1);

    begin_run(8'hA0, 8'd1, 1, 2, 1);
    finish_run(0, 1, 0, 1, 5, 2, 1);

    begin_run(8'hA0, 8'd1, 2, 4, 0);
    finish_run(0, 0, 1, 3, 0, 4, 0);
    repeat (10) step();
    check_eq("err_held", err, 1);

    begin_run(8'h5A, 8'd3, 0, 1, 1);
    for (int i = 0; i < 8000 && !(op == 8'h40 && bits == 40); i++) step();
    check_eq("reached_read", op, 8'h40);
    lrst = 1'b1;
    step();
    check_reset_state("midrst");
    lrst = 1'b0;
    repeat (3) step();

    begin_run(8'hC3, 8'd7, 0, 1, 1);
    finish_run(0, 1, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
